fpdiv_issue_ctrl: RTL

//  Upstream issue/capture stage for the multi-cycle fpdiv unit (divide/sqrt).

---
 rtl/fpdiv_pkg.sv | 27 ++
 rtl/fpdiv_issue_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fpdiv_pkg.sv
// Shared types and constants for the fpdiv issue/capture stage.
package fpdiv_pkg;

   typedef enum logic [1:0] {IDLE, START, WAIT, RESP} issue_state_t;

   typedef struct packed {
      logic [63:0] result;
      logic [4:0]  flags;
      logic        denorm;
      logic        timeout;
   } fpdiv_rsp_t;

   localparam logic [2:0] RM_RNE = 3'b000;
   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;

   // Response reported when the watchdog gives up on an op.
   function automatic fpdiv_rsp_t timeout_rsp();
      fpdiv_rsp_t r;
      r         = '0;
      r.timeout = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/fpdiv_issue_ctrl.sv
// Issue/capture stage in front of the multi-cycle fpdiv unit: one op in flight,
// start held for START_CYCLES, result captured on done or watchdog expiry.
module fpdiv_issue_ctrl
   import fpdiv_pkg::*;
#(
   parameter int START_CYCLES = 2,
   parameter int TIMEOUT      = 31
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [63:0]  in_op1,
   input  logic [63:0]  in_op2,
   input  logic [2:0]   in_rm,
   input  logic         in_op_type,
   input  logic         in_P,
   input  logic         in_OvEn,
   input  logic         in_UnEn,
   output logic [63:0]  op1,
   output logic [63:0]  op2,
   output logic [2:0]   rm,
   output logic         op_type,
   output logic         P,
   output logic         OvEn,
   output logic         UnEn,
   output logic         start,
   input  logic         done,
   input  logic [63:0]  AS_Result,
   input  logic [4:0]   Flags,
   input  logic         Denorm,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [63:0]  out_result,
   output logic [4:0]   out_flags,
   output logic         out_denorm,
   output logic         out_timeout,
   output logic         busy,
   output issue_state_t dbg_state
);

   localparam int SCNT_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
   localparam int WCNT_W = $clog2(TIMEOUT + 1);
   localparam logic [SCNT_W-1:0] SCNT_INIT = SCNT_W'(START_CYCLES - 1);
   localparam logic [WCNT_W-1:0] WCNT_MAX  = WCNT_W'(TIMEOUT);

   // Handshakes: a transfer happens on a rising clk edge where valid && ready.
   // The producer holds valid and its payload until that edge; ready may depend
   // on state only, never combinationally on valid.

   issue_state_t      state_q, state_d;
   logic [SCNT_W-1:0] scnt_q, scnt_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic              armed_q, armed_d;
   logic              start_d;
   logic              out_valid_d;
   fpdiv_rsp_t        rsp_q, rsp_d;
   logic              accept;

   always_comb begin
      state_d     = state_q;
      scnt_d      = scnt_q;
      wcnt_d      = wcnt_q;
      armed_d     = armed_q;
      start_d     = start;
      out_valid_d = out_valid;
      rsp_d       = rsp_q;
      accept      = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               accept  = 1'b1;
               start_d = 1'b1;
               scnt_d  = SCNT_INIT;
               armed_d = 1'b0;
               state_d = START;
            end
         end
         START: begin
            // A done still high from the previous op must drop before we trust it.
            if (!done) armed_d = 1'b1;
            if (scnt_q == '0) begin
               start_d = 1'b0;
               wcnt_d  = '0;
               state_d = WAIT;
            end else begin
               scnt_d = scnt_q - 1'b1;
            end
         end
         WAIT: begin
            if (!done) armed_d = 1'b1;
            if (armed_q && done) begin
               rsp_d       = '{result: AS_Result, flags: Flags, denorm: Denorm, timeout: 1'b0};
               out_valid_d = 1'b1;
               state_d     = RESP;
            end else if (wcnt_q == WCNT_MAX) begin
               rsp_d       = timeout_rsp();
               out_valid_d = 1'b1;
               state_d     = RESP;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         RESP: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         scnt_q    <= '0;
         wcnt_q    <= '0;
         armed_q   <= 1'b0;
         start     <= 1'b0;
         out_valid <= 1'b0;
         rsp_q     <= '0;
         op1       <= '0;
         op2       <= '0;
         rm        <= '0;
         op_type   <= 1'b0;
         P         <= 1'b0;
         OvEn      <= 1'b0;
         UnEn      <= 1'b0;
      end else begin
         state_q   <= state_d;
         scnt_q    <= scnt_d;
         wcnt_q    <= wcnt_d;
         armed_q   <= armed_d;
         start     <= start_d;
         out_valid <= out_valid_d;
         rsp_q     <= rsp_d;
         // Operand pins persist past completion until the next accept.
         if (accept) begin
            op1     <= in_op1;
            op2     <= in_op2;
            rm      <= in_rm;
            op_type <= in_op_type;
            P       <= in_P;
            OvEn    <= in_OvEn;
            UnEn    <= in_UnEn;
         end
      end
   end

   assign in_ready    = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign dbg_state   = state_q;
   assign out_result  = rsp_q.result;
   assign out_flags   = rsp_q.flags;
   assign out_denorm  = rsp_q.denorm;
   assign out_timeout = rsp_q.timeout;

endmodule
